// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
// The controller side drives operands and start; the adder side returns
// busy, the done strobe and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b and cin on an accepted start, then adds
// LSB-first through one full-adder cell with a registered carry, one bit per
// clock. The result is written to sum/cout on the edge that enters DONE and
// is held there until the next completed operation.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    // Bit counter only has to reach WIDTH-1; it never wraps within an op.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The single full-adder cell working on the current LSBs.
    logic s_bit;
    logic maj;
    assign s_bit = ra_q[0] ^ rb_q[0] ^ c_q;
    assign maj   = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    c_d     = bus.cin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                c_d   = maj;
                sr_d  = {s_bit, sr_q[WIDTH-1:1]};
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {s_bit, sr_q[WIDTH-1:1]};
                    cout_d  = maj;
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are flopped alongside the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] hold_sum  = '0;
    logic         hold_cout = 1'b0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full op: accept edge, 7 quiet shift edges, done edge, return-to-idle edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] esum, input logic ecout, input string tag);
        logic ok;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'hA5;
        bus.b     = 8'h5A;
        bus.cin   = 1'b1;
        check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
        ok = 1'b1;
        repeat (7) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b1 ||
                bus.sum !== hold_sum || bus.cout !== hold_cout) ok = 1'b0;
        end
        check({tag, " shift quiet and held"}, 32'(ok), 32'd1);
        tick();
        check({tag, " done at edge 8"}, 32'(bus.done), 32'd1);
        check({tag, " busy during done"}, 32'(bus.busy), 32'd1);
        check({tag, " sum"}, 32'(bus.sum), 32'(esum));
        check({tag, " cout"}, 32'(bus.cout), 32'(ecout));
        hold_sum  = esum;
        hold_cout = ecout;
        tick();
        check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        check({tag, " busy low after edge 9"}, 32'(bus.busy), 32'd0);
        check({tag, " sum held in idle"}, 32'(bus.sum), 32'(esum));
    endtask

    initial begin
        logic ok;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum",  32'(bus.sum),  32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Start on the first edge after reset release; 0x3C+0x0F+1 = 0x04C.
        do_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "basic");

        // Carry chains: 0xFF+0x01 = 0x100, 0xFF+0xFF+1 = 0x1FF.
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry1");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry2");

        // Start pulsed at edge 3 while busy must be dropped; 0x12+0x34 = 0x46.
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b0;
        tick();                       // edge 0
        bus.start = 1'b0;
        tick();                       // edge 1
        tick();                       // edge 2
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        tick();                       // edge 3
        bus.start = 1'b0;
        ok = 1'b1;
        repeat (4) begin              // edges 4..7
            tick();
            if (bus.done !== 1'b0) ok = 1'b0;
        end
        check("drop no early done", 32'(ok), 32'd1);
        tick();                       // edge 8
        check("drop done", 32'(bus.done), 32'd1);
        check("drop sum",  32'(bus.sum),  32'h46);
        check("drop cout", 32'(bus.cout), 32'd0);
        tick();                       // edge 9
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("drop no second op", 32'(ok), 32'd1);
        hold_sum  = 8'h46;
        hold_cout = 1'b0;

        // Reset in the middle of an operation: no done, result cleared.
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.cin   = 1'b0;
        tick();                       // edge 0
        bus.start = 1'b0;
        repeat (4) tick();            // edges 1..4
        check("midop sum held", 32'(bus.sum), 32'h46);
        #2 rst = 1'b1;
        #1;
        check("midop reset busy", 32'(bus.busy), 32'd0);
        check("midop reset done", 32'(bus.done), 32'd0);
        check("midop reset sum",  32'(bus.sum),  32'd0);
        check("midop reset cout", 32'(bus.cout), 32'd0);
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (bus.done !== 1'b0) ok = 1'b0;
        end
        check("midop no done", 32'(ok), 32'd1);
        rst       = 1'b0;
        hold_sum  = '0;
        hold_cout = 1'b0;
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after reset");

        // Start held high: done at edges 8, 18, 28; sum 0x02 each time.
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        tick();                       // edge 0
        for (int k = 0; k < 3; k++) begin
            ok = 1'b1;
            repeat (7) begin
                tick();
                if (bus.done !== 1'b0 || bus.sum !== hold_sum || bus.cout !== hold_cout) ok = 1'b0;
            end
            check("b2b quiet and held", 32'(ok), 32'd1);
            tick();
            check("b2b done", 32'(bus.done), 32'd1);
            check("b2b sum",  32'(bus.sum),  32'h02);
            check("b2b cout", 32'(bus.cout), 32'd0);
            hold_sum  = 8'h02;
            hold_cout = 1'b0;
            tick();
            check("b2b idle gap", 32'(bus.busy), 32'd0);
            tick();
            check("b2b re-accept", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
